// File: rtl/rv_ls_decode_issue.sv
`timescale 1ns/1ps
// rv_ls_decode_issue
// Decodes one RISC-V LOAD/STORE instruction at a time and runs it as a single
// data-memory transaction. Load results go back to the register file through a
// writeback pulse. Every accepted instruction retires with a done pulse, which
// is flagged as an exception when the instruction is illegal, misaligned, or
// when memory does not answer in time.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr    instruction handshake and word
//   in_rs1_val, in_rs2_val        base register and store source values
//   mem_req_*                     request channel (addr, wdata, wstrb, is_load, size)
//   mem_rsp_valid/mem_rsp_rdata   response or store acknowledge, raw aligned word
//   wb_valid/wb_rd/wb_data        one-cycle load writeback
//   done_valid/exc_valid/exc_cause retire pulse and exception qualifier
module rv_ls_decode_issue #(
    parameter int XLEN           = 32,   // only 32 is supported
    parameter int TIMEOUT_CYCLES = 256   // >= 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [3:0]      mem_req_wstrb,
    output logic            mem_req_is_load,
    output logic [2:0]      mem_req_size,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done_valid,
    output logic            exc_valid,
    output logic [1:0]      exc_cause
);

    localparam logic [6:0] OPC_LOAD         = 7'b0000011;
    localparam logic [6:0] OPC_STORE        = 7'b0100011;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;
    localparam int         CNT_W            = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

    state_t state_q, state_d;

    // ---------------------------------------------------------------
    // Decode straight from the offered instruction so the accept edge
    // already knows whether to issue or to retire with an exception.
    // ---------------------------------------------------------------
    logic [6:0]      dec_opcode;
    logic [2:0]      dec_funct3;
    logic            dec_is_load, dec_is_store;
    logic            dec_legal, dec_misaligned;
    logic [XLEN-1:0] dec_imm, dec_addr, dec_wdata;
    logic [3:0]      dec_wstrb;
    logic            unused_rs1_idx;

    assign dec_opcode   = in_instr[6:0];
    assign dec_funct3   = in_instr[14:12];
    assign dec_is_load  = (dec_opcode == OPC_LOAD);
    assign dec_is_store = (dec_opcode == OPC_STORE);
    // The rs1 index is resolved upstream; only its value arrives here.
    assign unused_rs1_idx = ^in_instr[19:15];

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        dec_legal      = 1'b0;
        dec_imm        = '0;
        dec_addr       = '0;
        dec_wdata      = '0;
        dec_wstrb      = 4'b0000;
        dec_misaligned = 1'b0;
        if (dec_is_load) begin
            dec_legal = dec_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        end else if (dec_is_store) begin
            dec_legal = dec_funct3 inside {3'b000, 3'b001, 3'b010};
            dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        dec_addr = in_rs1_val + dec_imm;   // wraps modulo 2^XLEN
        dec_misaligned = (dec_funct3[1:0] == 2'b01 && dec_addr[0]) ||
                         (dec_funct3[1:0] == 2'b10 && dec_addr[1:0] != 2'b00);
        if (dec_is_store) begin
            case (dec_funct3[1:0])
                2'b00: begin
                    dec_wdata = {4{in_rs2_val[7:0]}};
                    dec_wstrb = 4'b0001 << dec_addr[1:0];
                end
                2'b01: begin
                    dec_wdata = {2{in_rs2_val[15:0]}};
                    dec_wstrb = 4'b0011 << dec_addr[1:0];
                end
                default: begin
                    dec_wdata = in_rs2_val;
                    dec_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Transaction registers
    // ---------------------------------------------------------------
    logic [XLEN-1:0]  addr_q, wdata_q, rdata_q;
    logic [3:0]       wstrb_q;
    logic             is_load_q, exc_q;
    logic [2:0]       funct3_q;
    logic [4:0]       rd_q;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept, cnt_last, rsp_taken, timeout_hit;

    assign accept   = (state_q == IDLE) && in_valid;
    assign cnt_last = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A response wins over a timeout landing in the same cycle. In ISSUE a
    // response only counts together with mem_req_ready.
    always_comb begin
        state_d     = state_q;
        rsp_taken   = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid)
                    state_d = (!dec_legal || dec_misaligned) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (mem_req_ready && mem_rsp_valid) begin
                    rsp_taken = 1'b1;
                    state_d   = DONE;
                end else if (cnt_last) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end else if (mem_req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    rsp_taken = 1'b1;
                    state_d   = DONE;
                end else if (cnt_last) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;   // DONE lasts exactly one cycle
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= 4'b0000;
            is_load_q <= 1'b0;
            exc_q     <= 1'b0;
            funct3_q  <= 3'b000;
            rd_q      <= 5'd0;
            cause_q   <= 2'b00;
            cnt_q     <= '0;
        end else if (accept) begin
            addr_q    <= dec_addr;
            wdata_q   <= dec_wdata;
            wstrb_q   <= dec_wstrb;
            is_load_q <= dec_is_load;
            funct3_q  <= dec_funct3;
            rd_q      <= in_instr[11:7];
            exc_q     <= !dec_legal || dec_misaligned;
            cause_q   <= !dec_legal ? CAUSE_ILLEGAL :
                         (dec_misaligned ? CAUSE_MISALIGNED : 2'b00);
            cnt_q     <= '0;
        end else begin
            if (state_q == ISSUE || state_q == WAIT_RSP)
                cnt_q <= cnt_q + 1'b1;
            if (rsp_taken)
                rdata_q <= mem_rsp_rdata;
            if (timeout_hit) begin
                exc_q   <= 1'b1;
                cause_q <= CAUSE_TIMEOUT;
            end
        end
    end

    // ---------------------------------------------------------------
    // Load extraction: shift the addressed lane down to bit 0. Halves are
    // aligned and words sit at lane 0, so one shift serves every size.
    // ---------------------------------------------------------------
    logic [XLEN-1:0] rdata_shift, ld_data;

    always_comb begin
        rdata_shift = rdata_q >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  ld_data = {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, rdata_shift[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, rdata_shift[15:0]};
            default: ld_data = rdata_shift;
        endcase
    end

    // ---------------------------------------------------------------
    // Outputs: request fields only while ISSUE, retire fields only in DONE
    // ---------------------------------------------------------------
    logic in_issue, in_done;

    assign in_issue = (state_q == ISSUE);
    assign in_done  = (state_q == DONE);

    assign in_ready        = (state_q == IDLE);
    assign mem_req_valid   = in_issue;
    assign mem_req_addr    = in_issue ? addr_q : '0;
    assign mem_req_wdata   = in_issue ? wdata_q : '0;
    assign mem_req_wstrb   = in_issue ? wstrb_q : 4'b0000;
    assign mem_req_is_load = in_issue && is_load_q;
    assign mem_req_size    = in_issue ? {1'b0, funct3_q[1:0]} : 3'b000;

    assign done_valid = in_done;
    assign exc_valid  = in_done && exc_q;
    assign exc_cause  = (in_done && exc_q) ? cause_q : 2'b00;

    assign wb_valid = in_done && !exc_q && is_load_q && (rd_q != 5'd0);
    assign wb_rd    = wb_valid ? rd_q : 5'd0;
    assign wb_data  = wb_valid ? ld_data : '0;

endmodule
